// File: rtl/mem_port_arbiter.sv
// Shares one AHB-Lite master port between instruction fetch and data accesses.
// It arbitrates each address phase and routes completions back to the requester that owns the data phase.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [2:0]  dm_size,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        bus_err,
  output logic        stall,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  localparam logic [2:0] FETCH_SIZE = 3'b010;

  logic       dphase_valid;
  logic       dphase_owner;   // 1 = data requester owns the data phase
  logic       dphase_write;
  logic       cancel;
  logic [3:0] starve_cnt;

  logic arb_en;
  logic fetch_forced;
  logic dm_win;
  logic if_win;
  logic done;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    // rst gates the grants so that all outputs read 0 for as long as reset is held.
    arb_en       = rst & HREADY & ~cancel;
    fetch_forced = if_req & (starve_cnt == 4'(STARVE_MAX));
    dm_win       = arb_en & dm_req & ~fetch_forced;
    if_win       = arb_en & if_req & ~dm_win;

    if_gnt = if_win;
    dm_gnt = dm_win;
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = '0;
    if (dm_win) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = dm_addr;
      HWRITE = dm_write;
      HSIZE  = dm_size;
    end else if (if_win) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = if_addr;
      HSIZE  = FETCH_SIZE;
    end

    done      = dphase_valid & HREADY;
    if_rvalid = done & ~dphase_owner;
    dm_rvalid = done & dphase_owner;
    if_rdata  = if_rvalid ? HRDATA : '0;
    dm_rdata  = (dm_rvalid & ~dphase_write) ? HRDATA : '0;
    bus_err   = done & HRESP;

    stall = rst & ((dm_req & ~dm_win) | (dphase_valid & dphase_owner & ~HREADY));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dphase_valid <= 1'b0;
      dphase_owner <= 1'b0;
      dphase_write <= 1'b0;
      HWDATA       <= '0;
      starve_cnt   <= '0;
      cancel       <= 1'b0;
    end else begin
      // An ERROR response ends on the cycle where HREADY is high. The cycle after its first half issues no grant.
      if (HREADY)
        cancel <= 1'b0;
      else if (HRESP)
        cancel <= 1'b1;

      if (HREADY) begin
        dphase_valid <= if_win | dm_win;
        dphase_owner <= dm_win;
        dphase_write <= dm_win & dm_write;
        if (dm_win && dm_write)
          HWDATA <= dm_wdata;

        if (if_win || !if_req)
          starve_cnt <= '0;
        else if (dm_win && starve_cnt != 4'(STARVE_MAX))
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule
